// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu into HI/LO,
// single-edge mthi/mtlo, busy/stall interface toward the hazard unit.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_LOG    = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CNT_W      = (CNT_LOG > 4) ? CNT_LOG : 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             busy_d;
  logic [31:0]      hi_d, lo_d;
  logic             accept;

  // Result datapath on the latched operands; op_q[0] clear means signed.
  logic        is_signed, is_div, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quo, rem;

  always_comb begin
    is_signed = ~op_q[0];
    is_div    = op_q[1];
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_ext     = {{32{a_neg}}, a_q};
    b_ext     = {{32{b_neg}}, b_q};
    prod      = a_ext * b_ext;
    dvd       = a_neg ? (32'd0 - a_q) : a_q;
    dvs       = b_neg ? (32'd0 - b_q) : b_q;
    // Divisor forced nonzero only to keep the datapath defined; result is discarded.
    dvs_safe  = (dvs == 32'd0) ? 32'd1 : dvs;
    q_mag     = dvd / dvs_safe;
    r_mag     = dvd % dvs_safe;
    quo       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem       = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  assign accept    = start & ~cancel & ~busy;
  assign stall_req = busy | (start & ~cancel & ~op[2]);

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy;
    hi_d    = hi;
    lo_d    = lo;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!is_div) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy    <= busy_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

endmodule
